// File: rtl/pixel_cfg_fsm_pkg.sv
// Shared types and counter command encodings for the pixel configuration,
// scan and process sequencers.
package pixel_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ROW_SET,
    ROW_WR,
    COL_SET,
    COL_WR,
    RAM_RD,
    RAM_WAIT,
    KEY_WR,
    DONE,
    WAIT_LOW
  } state_e;

  // RAM address counter commands
  localparam logic [4:0] CNT_RST  = 5'b10000;
  localparam logic [4:0] CNT_INC  = 5'b00001;
  localparam logic [4:0] CNT_HOLD = 5'b00000;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_cfg_fsm_if.sv
// Configuration grant and chip-driver signals of the pixel configuration
// sequencer. The sequencer is the slave; arbiter/chip side is the master.
interface pixel_cfg_fsm_if;

  logic       i_cfg_go;
  logic       i_zero_mode;
  logic [4:0] o_col_control;
  logic [4:0] o_row_control;
  logic       o_ram_read;
  logic       o_key_zero;
  logic       o_row_reg_data;
  logic       o_row_reg_write;
  logic       o_col_reg_data;
  logic       o_col_reg_write;
  logic       o_key_wren;
  logic       o_cfg_end;

  modport master (
    output i_cfg_go, i_zero_mode,
    input  o_col_control, o_row_control, o_ram_read, o_key_zero,
           o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write,
           o_key_wren, o_cfg_end
  );

  modport slave (
    input  i_cfg_go, i_zero_mode,
    output o_col_control, o_row_control, o_ram_read, o_key_zero,
           o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write,
           o_key_wren, o_cfg_end
  );

endinterface

// File: rtl/pixel_cfg_fsm_shift.sv
// Two-cycle serial shift generator: a set cycle presents the data bit,
// the following write cycle keeps it and raises the shift pulse.
module cfg_shift_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic write_i,
  input  logic bit_i,
  output logic data_o,
  output logic write_o
);

  logic data_q, data_d;
  logic write_q, write_d;

  // Data/strobe for the coming cycle; idle outputs are low
  always_comb begin
    data_d  = 1'b0;
    write_d = 1'b0;
    if (set_i) begin
      data_d = bit_i;
    end else if (write_i) begin
      data_d  = data_q;
      write_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      write_q <= write_d;
    end
  end

  assign data_o  = data_q;
  assign write_o = write_q;

endmodule

// File: rtl/pixel_cfg_fsm.sv
// Pixel matrix configuration sequencer: walks every pixel row by row,
// shifts one-hot row/column tokens, fetches the key from RAM and pulses
// the key write enable. Zero mode writes zeros without reading RAM.
module pixel_cfg_fsm
  import pixel_cfg_pkg::*;
#(
  parameter int unsigned N_ROWS    = 24,
  parameter int unsigned N_COLS    = 24,
  parameter int unsigned RAM_LAT   = 2,
  parameter int unsigned KEY_PULSE = 2
) (
  input logic           clk,
  input logic           rst_n,
  pixel_cfg_fsm_if.slave bus
);

  localparam int unsigned RW = idx_width(N_ROWS);
  localparam int unsigned CW = idx_width(N_COLS);
  localparam int unsigned WW = idx_width((RAM_LAT > KEY_PULSE) ? RAM_LAT : KEY_PULSE);

  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [WW-1:0] WAIT_RAM = WW'(RAM_LAT - 1);
  localparam logic [WW-1:0] WAIT_KEY = WW'(KEY_PULSE - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          zero_q, zero_d;

  logic [4:0]    col_ctrl_q, col_ctrl_d;
  logic [4:0]    row_ctrl_q, row_ctrl_d;
  logic          ram_read_q, ram_read_d;
  logic          key_zero_q, key_zero_d;
  logic          key_wren_q, key_wren_d;
  logic          cfg_end_q, cfg_end_d;

  logic          row_set, row_wr, col_set, col_wr;

  // Next state, indices, wait counter and latched zero mode
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wait_d  = wait_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.i_cfg_go) begin
          zero_d  = bus.i_zero_mode;
          row_d   = '0;
          col_d   = '0;
          state_d = ROW_SET;
        end
      end
      ROW_SET: state_d = ROW_WR;
      ROW_WR: begin
        col_d   = '0;
        state_d = COL_SET;
      end
      COL_SET: state_d = COL_WR;
      COL_WR:  state_d = RAM_RD;
      RAM_RD: begin
        wait_d  = WAIT_RAM;
        state_d = RAM_WAIT;
      end
      RAM_WAIT: begin
        if (wait_q == '0) begin
          wait_d  = WAIT_KEY;
          state_d = KEY_WR;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      KEY_WR: begin
        if (wait_q == '0) begin
          if (col_q != COL_LAST) begin
            col_d   = col_q + CW'(1);
            state_d = COL_SET;
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + RW'(1);
            state_d = ROW_SET;
          end else begin
            state_d = DONE;
          end
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      DONE: state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!bus.i_cfg_go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Losing the grant mid-operation abandons the walk immediately
    if (!bus.i_cfg_go && (state_q != IDLE) && (state_q != WAIT_LOW)) state_d = IDLE;
  end

  // Output decode from the next state so registered outputs line up with
  // the state they describe
  always_comb begin
    col_ctrl_d = CNT_HOLD;
    row_ctrl_d = CNT_HOLD;
    ram_read_d = 1'b0;
    key_wren_d = 1'b0;
    cfg_end_d  = 1'b0;
    key_zero_d = (state_d != IDLE) && zero_d;
    row_set    = (state_d == ROW_SET);
    row_wr     = (state_d == ROW_WR);
    col_set    = (state_d == COL_SET);
    col_wr     = (state_d == COL_WR);
    case (state_d)
      IDLE: begin
        col_ctrl_d = CNT_RST;
        row_ctrl_d = CNT_RST;
      end
      RAM_RD: ram_read_d = !zero_d;
      KEY_WR: begin
        key_wren_d = 1'b1;
        if (wait_d == '0) begin
          col_ctrl_d = CNT_INC;
          if ((col_d == COL_LAST) && (row_d != ROW_LAST)) begin
            col_ctrl_d = CNT_RST;
            row_ctrl_d = CNT_INC;
          end
        end
      end
      DONE: cfg_end_d = 1'b1;
      default: ;
    endcase
  end

  // State, index and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      wait_q     <= '0;
      zero_q     <= 1'b0;
      col_ctrl_q <= CNT_RST;
      row_ctrl_q <= CNT_RST;
      ram_read_q <= 1'b0;
      key_zero_q <= 1'b0;
      key_wren_q <= 1'b0;
      cfg_end_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wait_q     <= wait_d;
      zero_q     <= zero_d;
      col_ctrl_q <= col_ctrl_d;
      row_ctrl_q <= row_ctrl_d;
      ram_read_q <= ram_read_d;
      key_zero_q <= key_zero_d;
      key_wren_q <= key_wren_d;
      cfg_end_q  <= cfg_end_d;
    end
  end

  cfg_shift_strobe u_row_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_i   (row_set),
    .write_i (row_wr),
    .bit_i   (row_d == '0),
    .data_o  (bus.o_row_reg_data),
    .write_o (bus.o_row_reg_write)
  );

  cfg_shift_strobe u_col_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_i   (col_set),
    .write_i (col_wr),
    .bit_i   (col_d == '0),
    .data_o  (bus.o_col_reg_data),
    .write_o (bus.o_col_reg_write)
  );

  assign bus.o_col_control = col_ctrl_q;
  assign bus.o_row_control = row_ctrl_q;
  assign bus.o_ram_read    = ram_read_q;
  assign bus.o_key_zero    = key_zero_q;
  assign bus.o_key_wren    = key_wren_q;
  assign bus.o_cfg_end     = cfg_end_q;

endmodule

// File: tb/tb_pixel_cfg_fsm.sv
// Bench for pixel_cfg_fsm: a 2x3 instance and a degenerate 1x1 instance,
// checked every cycle against a timeline model derived from the walk rules.
module tb_pixel_cfg_fsm;
  import pixel_cfg_pkg::*;

  typedef struct packed {
    logic [4:0] col_ctrl;
    logic [4:0] row_ctrl;
    logic       ram_read;
    logic       key_zero;
    logic       row_data;
    logic       row_wr;
    logic       col_data;
    logic       col_wr;
    logic       key_wren;
    logic       cfg_end;
  } obs_t;

  int nr_p[2] = '{2, 1};
  int nc_p[2] = '{3, 1};
  int rl_p[2] = '{2, 1};
  int kp_p[2] = '{2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go_a = 1'b0, zm_a = 1'b0, go_b = 1'b0, zm_b = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pixel_cfg_fsm_if bus_a ();
  pixel_cfg_fsm_if bus_b ();

  assign bus_a.i_cfg_go    = go_a;
  assign bus_a.i_zero_mode = zm_a;
  assign bus_b.i_cfg_go    = go_b;
  assign bus_b.i_zero_mode = zm_b;

  pixel_cfg_fsm #(.N_ROWS(2), .N_COLS(3), .RAM_LAT(2), .KEY_PULSE(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  pixel_cfg_fsm #(.N_ROWS(1), .N_COLS(1), .RAM_LAT(1), .KEY_PULSE(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.o_col_control, bus_a.o_row_control, bus_a.o_ram_read, bus_a.o_key_zero,
                  bus_a.o_row_reg_data, bus_a.o_row_reg_write, bus_a.o_col_reg_data,
                  bus_a.o_col_reg_write, bus_a.o_key_wren, bus_a.o_cfg_end};
  assign obs_b = {bus_b.o_col_control, bus_b.o_row_control, bus_b.o_ram_read, bus_b.o_key_zero,
                  bus_b.o_row_reg_data, bus_b.o_row_reg_write, bus_b.o_col_reg_data,
                  bus_b.o_col_reg_write, bus_b.o_key_wren, bus_b.o_cfg_end};

  function automatic obs_t get_obs(input int sel);
    return (sel == 0) ? obs_a : obs_b;
  endfunction

  function automatic int total_cycles(input int sel);
    return nr_p[sel] * (2 + nc_p[sel] * (3 + rl_p[sel] + kp_p[sel]));
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    e.col_ctrl = 5'b10000;
    e.row_ctrl = 5'b10000;
    return e;
  endfunction

  function automatic obs_t wait_exp(input bit zm);
    obs_t e;
    e = '0;
    e.key_zero = zm;
    return e;
  endfunction

  // Expected outputs t cycles after the first ROW_SET, from the walk timeline:
  // each row = 2 shift cycles + per pixel (col set, col write, read, RAM_LAT wait, KEY_PULSE key)
  function automatic obs_t model(input int t, input bit zm, input int sel);
    obs_t e;
    int nr, nc, rl, kp, pix, row_len, row, r, c, p;
    nr = nr_p[sel]; nc = nc_p[sel]; rl = rl_p[sel]; kp = kp_p[sel];
    pix = 3 + rl + kp;
    row_len = 2 + nc * pix;
    e = '0;
    e.key_zero = zm;
    if (t == nr * row_len) begin
      e.cfg_end = 1'b1;
      return e;
    end
    row = t / row_len;
    r = t % row_len;
    if (r < 2) begin
      e.row_data = (row == 0);
      e.row_wr   = (r == 1);
    end else begin
      c = (r - 2) / pix;
      p = (r - 2) % pix;
      if (p < 2) begin
        e.col_data = (c == 0);
        e.col_wr   = (p == 1);
      end else if (p == 2) begin
        e.ram_read = !zm;
      end else if (p >= 3 + rl) begin
        e.key_wren = 1'b1;
        if (p == pix - 1) begin
          if (c == nc - 1 && row < nr - 1) begin
            e.col_ctrl = 5'b10000;
            e.row_ctrl = 5'b00001;
          end else begin
            e.col_ctrl = 5'b00001;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input obs_t obs, input obs_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_go(input int sel, input logic v);
    if (sel == 0) go_a = v; else go_b = v;
  endtask

  task automatic set_zm(input int sel, input logic v);
    if (sel == 0) zm_a = v; else zm_b = v;
  endtask

  // One operation: abort_at < 0 runs to completion, then holds go for 'hold' cycles
  task automatic run_op(input int sel, input bit zm, input int abort_at, input int hold,
                        input bit scramble);
    int tot, ends;
    tot = total_cycles(sel);
    ends = 0;
    @(negedge clk);
    check($sformatf("idle_pre_%0d", sel), get_obs(sel), idle_exp());
    set_zm(sel, zm);
    set_go(sel, 1'b1);
    for (int t = 0; t <= tot; t++) begin
      @(negedge clk);
      check($sformatf("run%0d_zm%0d_t%0d", sel, zm, t), get_obs(sel), model(t, zm, sel));
      if (get_obs(sel).cfg_end === 1'b1) ends++;
      if (scramble) set_zm(sel, 1'($urandom_range(0, 1)));
      if (t == abort_at) begin
        set_go(sel, 1'b0);
        @(negedge clk);
        check($sformatf("abort_idle_%0d_t%0d", sel, t), get_obs(sel), idle_exp());
        check_int("abort_no_end", ends, 0);
        return;
      end
    end
    check_int($sformatf("end_count_%0d", sel), ends, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("wait_low_%0d_h%0d", sel, h), get_obs(sel), wait_exp(zm));
    end
    set_go(sel, 1'b0);
    @(negedge clk);
    check($sformatf("idle_post_%0d", sel), get_obs(sel), idle_exp());
  endtask

  // Start an operation and assert reset asynchronously in the first KEY_WR cycle
  task automatic reset_mid_key(input int sel);
    int tk;
    tk = 2 + 3 + rl_p[sel];
    @(negedge clk);
    check("rst_pre_idle", get_obs(sel), idle_exp());
    set_zm(sel, 1'b0);
    set_go(sel, 1'b1);
    for (int t = 0; t <= tk; t++) begin
      @(negedge clk);
      check($sformatf("rst_run_t%0d", t), get_obs(sel), model(t, 1'b0, sel));
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", get_obs(sel), idle_exp());
    set_go(sel, 1'b0);
    @(negedge clk);
    check("reset_held", get_obs(sel), idle_exp());
    rst_n = 1'b1;
  endtask

  initial begin
    int sel, abort_at, hold, tot;
    bit zm, scr;

    repeat (2) @(negedge clk);
    check("reset_a", obs_a, idle_exp());
    check("reset_b", obs_b, idle_exp());
    rst_n = 1'b1;

    run_op(0, 1'b0, -1, 10, 1'b0);
    run_op(0, 1'b1, -1, 2, 1'b0);
    run_op(0, 1'b0, 19, 0, 1'b0);
    run_op(0, 1'b0, -1, 1, 1'b1);
    run_op(1, 1'b0, -1, 3, 1'b0);
    run_op(1, 1'b1, -1, 0, 1'b0);
    reset_mid_key(0);
    run_op(0, 1'b1, -1, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 1));
      zm = 1'($urandom_range(0, 1));
      tot = total_cycles(sel);
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
      hold = int'($urandom_range(0, 4));
      scr = 1'($urandom_range(0, 1));
      run_op(sel, zm, abort_at, hold, scr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
